// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Purpose:
//   Generates VGA raster timing (640x480 @ 60 Hz by default) and the pixel
//   coordinates consumed by the background/sprite renderers. It also provides
//   line/frame strobes and a frame counter for game-logic pacing.
//
// Optional feature (compile-time macro):
//   VGA_SYNC_ALIGN_EN - when defined, hs/vs pass through SYNC_DELAY extra
//                       register stages (reset to 1). This lines them up with
//                       RGB from renderers that register their palette output
//                       one cycle after DrawX. DrawX/DrawY/blank/strobes are
//                       never delayed. When undefined, hs/vs are aligned with
//                       DrawX/DrawY.
//
// Ports:
//   vga_clk      in   1   pixel clock (25 MHz at defaults), posedge only
//   reset_n      in   1   asynchronous active-low reset
//   run          in   1   1 = advance one pixel per cycle, 0 = freeze everything
//   DrawX        out  10  horizontal count, 0..H_TOTAL-1
//   DrawY        out  10  vertical count,   0..V_TOTAL-1
//   blank        out  1   1 = visible pixel, 0 = blanking interval
//   hs           out  1   horizontal sync, active low
//   vs           out  1   vertical sync, active low
//   line_end     out  1   high while DrawX == H_TOTAL-1
//   frame_end    out  1   high while DrawX == H_TOTAL-1 and DrawY == V_TOTAL-1
//   frame_count  out  8   frames completed since reset, modulo 256
// -----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int SYNC_DELAY = 1
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    input  logic       run,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       line_end,
    output logic       frame_end,
    output logic [7:0] frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    // Last count of each axis, in counter width.
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    // Region boundaries are kept one bit wider than the counters so a sync
    // pulse ending exactly at 1024 still compares correctly.
    localparam logic [10:0] H_VIS_END  = 11'(H_VISIBLE);
    localparam logic [10:0] H_SYNC_BEG = 11'(H_VISIBLE + H_FP);
    localparam logic [10:0] H_SYNC_END = 11'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [10:0] V_VIS_END  = 11'(V_VISIBLE);
    localparam logic [10:0] V_SYNC_BEG = 11'(V_VISIBLE + V_FP);
    localparam logic [10:0] V_SYNC_END = 11'(V_VISIBLE + V_FP + V_SYNC);

    // Elaboration-time guards: the counters are 10 bits wide.
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end
    if (SYNC_DELAY < 1 || SYNC_DELAY > 4) begin : g_bad_delay
        $error("vga_timing_gen: SYNC_DELAY must be in 1..4");
    end

    // -------------------------------------------------------------------------
    // Next-count logic. Every registered output is derived from the next count
    // so that it is presented in the same cycle as the coordinate it describes.
    // -------------------------------------------------------------------------
    logic       h_wrap;
    logic       v_wrap;
    logic [9:0] h_next;
    logic [9:0] v_next;
    logic       blank_next;
    logic       hs_next;
    logic       vs_next;
    logic       line_end_next;
    logic       frame_end_next;

    always_comb begin
        // NOTE: every signal gets a default first so no path through this
        // block can leave a value unassigned and infer a latch.
        h_wrap         = (DrawX == H_LAST);
        v_wrap         = (DrawY == V_LAST);
        h_next         = DrawX + 10'd1;
        v_next         = DrawY;

        if (h_wrap) begin
            h_next = '0;
            v_next = v_wrap ? '0 : DrawY + 10'd1;
        end

        blank_next     = ({1'b0, h_next} < H_VIS_END) && ({1'b0, v_next} < V_VIS_END);
        hs_next        = !(({1'b0, h_next} >= H_SYNC_BEG) && ({1'b0, h_next} < H_SYNC_END));
        vs_next        = !(({1'b0, v_next} >= V_SYNC_BEG) && ({1'b0, v_next} < V_SYNC_END));
        line_end_next  = (h_next == H_LAST);
        frame_end_next = line_end_next && (v_next == V_LAST);
    end

    // -------------------------------------------------------------------------
    // Raster state. With run low nothing changes, so a strobe that is high
    // when run drops stays high until the count advances again.
    // -------------------------------------------------------------------------
    logic hs_raw;
    logic vs_raw;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (!reset_n) begin
            DrawX       <= '0;
            DrawY       <= '0;
            blank       <= 1'b1;
            hs_raw      <= 1'b1;
            vs_raw      <= 1'b1;
            line_end    <= 1'b0;
            frame_end   <= 1'b0;
            frame_count <= '0;
        end else if (run) begin
            DrawX     <= h_next;
            DrawY     <= v_next;
            blank     <= blank_next;
            hs_raw    <= hs_next;
            vs_raw    <= vs_next;
            line_end  <= line_end_next;
            frame_end <= frame_end_next;
            // A frame completes on the wrap out of the last pixel.
            if (h_wrap && v_wrap) begin
                frame_count <= frame_count + 8'd1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Sync output stage.
    // -------------------------------------------------------------------------
`ifdef VGA_SYNC_ALIGN_EN
    logic [SYNC_DELAY-1:0] hs_dly;
    logic [SYNC_DELAY-1:0] vs_dly;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        // NOTE: the delay stages are explicitly reset to the inactive sync
        // level; left unreset they would emit a spurious sync pulse after
        // reset release.
        if (!reset_n) begin
            hs_dly <= '1;
            vs_dly <= '1;
        end else if (run) begin
            hs_dly[0] <= hs_raw;
            vs_dly[0] <= vs_raw;
            for (int i = 1; i < SYNC_DELAY; i++) begin
                hs_dly[i] <= hs_dly[i-1];
                vs_dly[i] <= vs_dly[i-1];
            end
        end
    end

    assign hs = hs_dly[SYNC_DELAY-1];
    assign vs = vs_dly[SYNC_DELAY-1];
`else
    assign hs = hs_raw;
    assign vs = vs_raw;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Two instances share clock, reset and run: one with the default 640x480
// timing, and one with a tiny raster (8 x 6) so that full frames and the
// 8-bit frame counter wrap fit in a short run. Stimulus pushes the expected
// output vectors of both instances into a queue each cycle, and a separate
// monitor pops and compares them after every clock edge. Directed spot checks
// with hand-computed constants cover the listed corner cases.
// Expected sync timing assumes SYNC_DELAY = 1 when VGA_SYNC_ALIGN_EN is set.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

    logic clk;
    logic rst_n;
    logic run;

    logic [9:0] dx_d, dy_d, dx_s, dy_s;
    logic       bl_d, hs_d, vs_d, le_d, fe_d;
    logic       bl_s, hs_s, vs_s, le_s, fe_s;
    logic [7:0] fc_d, fc_s;

    vga_timing_gen u_def (
        .vga_clk(clk), .reset_n(rst_n), .run(run),
        .DrawX(dx_d), .DrawY(dy_d), .blank(bl_d), .hs(hs_d), .vs(vs_d),
        .line_end(le_d), .frame_end(fe_d), .frame_count(fc_d)
    );

    vga_timing_gen #(
        .H_VISIBLE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_VISIBLE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) u_sml (
        .vga_clk(clk), .reset_n(rst_n), .run(run),
        .DrawX(dx_s), .DrawY(dy_s), .blank(bl_s), .hs(hs_s), .vs(vs_s),
        .line_end(le_s), .frame_end(fe_s), .frame_count(fc_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vector order: {DrawX, DrawY, blank, hs, vs, line_end, frame_end, frame_count}
    logic [32:0] act_d, act_s;
    assign act_d = {dx_d, dy_d, bl_d, hs_d, vs_d, le_d, fe_d, fc_d};
    assign act_s = {dx_s, dy_s, bl_s, hs_s, vs_s, le_s, fe_s, fc_s};

    localparam logic [32:0] RESET_VEC = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [32:0] got, input logic [32:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- model
    int p_hv[2] = '{640, 4};
    int p_hf[2] = '{16, 1};
    int p_hs[2] = '{96, 2};
    int p_hb[2] = '{48, 1};
    int p_vv[2] = '{480, 3};
    int p_vf[2] = '{10, 1};
    int p_vs[2] = '{2, 1};
    int p_vb[2] = '{33, 1};

    int m_x[2], m_y[2], m_fc[2];
    bit m_hsd[2], m_vsd[2];

    function automatic int ht(int i);
        return p_hv[i] + p_hf[i] + p_hs[i] + p_hb[i];
    endfunction

    function automatic int vt(int i);
        return p_vv[i] + p_vf[i] + p_vs[i] + p_vb[i];
    endfunction

    function automatic bit raw_hs(int i, int x);
        return !(x >= p_hv[i] + p_hf[i] && x < p_hv[i] + p_hf[i] + p_hs[i]);
    endfunction

    function automatic bit raw_vs(int i, int y);
        return !(y >= p_vv[i] + p_vf[i] && y < p_vv[i] + p_vf[i] + p_vs[i]);
    endfunction

    function automatic logic [32:0] expv(int i);
        logic bl, hso, vso, le, fe;
        bl = (m_x[i] < p_hv[i]) && (m_y[i] < p_vv[i]);
        le = (m_x[i] == ht(i) - 1);
        fe = le && (m_y[i] == vt(i) - 1);
`ifdef VGA_SYNC_ALIGN_EN
        hso = m_hsd[i];
        vso = m_vsd[i];
`else
        hso = raw_hs(i, m_x[i]);
        vso = raw_vs(i, m_y[i]);
`endif
        return {10'(m_x[i]), 10'(m_y[i]), bl, hso, vso, le, fe, 8'(m_fc[i])};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_x[i] = 0; m_y[i] = 0; m_fc[i] = 0; m_hsd[i] = 1'b1; m_vsd[i] = 1'b1;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            m_hsd[i] = raw_hs(i, m_x[i]);
            m_vsd[i] = raw_vs(i, m_y[i]);
            if (m_x[i] == ht(i) - 1) begin
                m_x[i] = 0;
                if (m_y[i] == vt(i) - 1) begin
                    m_y[i]  = 0;
                    m_fc[i] = (m_fc[i] + 1) % 256;
                end else begin
                    m_y[i]++;
                end
            end else begin
                m_x[i]++;
            end
        end
    endtask

    // ----------------------------------------------------------- scoreboard
    typedef struct packed {
        logic [32:0] d;
        logic [32:0] s;
    } exp_t;

    exp_t exp_q[$];

    // Called at a falling edge: drives run for the next rising edge, queues
    // the response expected after it, and returns at the following falling edge.
    task automatic tick(input bit r);
        run = r;
        if (r) model_step();
        exp_q.push_back('{d: expv(0), s: expv(1)});
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_def", act_d, e.d);
                check("sb_sml", act_s, e.s);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion before %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------- stimulus
    initial begin : stimulus
        rst_n = 1'b0;
        run   = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_def", act_d, RESET_VEC);
        check("reset_sml", act_s, RESET_VEC);
        rst_n = 1'b1;

        // Line 0 and the start of line 1 on the default raster.
        for (int k = 1; k <= 900; k++) begin
            tick(1'b1);
            case (k)
                639: check("blank_639", 33'(bl_d), 33'(1));
                640: check("blank_640", 33'(bl_d), 33'(0));
`ifdef VGA_SYNC_ALIGN_EN
                656: check("hs_656", 33'(hs_d), 33'(1));
                657: check("hs_657", 33'(hs_d), 33'(0));
                752: check("hs_752", 33'(hs_d), 33'(0));
                753: check("hs_753", 33'(hs_d), 33'(1));
`else
                655: check("hs_655", 33'(hs_d), 33'(1));
                656: check("hs_656", 33'(hs_d), 33'(0));
                751: check("hs_751", 33'(hs_d), 33'(0));
                752: check("hs_752", 33'(hs_d), 33'(1));
`endif
                799: check("line_end_799", 33'({le_d, fe_d}), 33'(2'b10));
                800: check("wrap_800", 33'({dx_d, dy_d, le_d}), 33'({10'd0, 10'd1, 1'b0}));
                default: ;
            endcase
        end

        // Freeze at DrawX = 100 for 10 cycles, then resume.
        for (int k = 0; k < 10; k++) begin
            tick(1'b0);
            check("hold_xy", 33'({dx_d, dy_d}), 33'({10'd100, 10'd1}));
        end
        tick(1'b1);
        check("resume_xy", 33'({dx_d, dy_d}), 33'({10'd101, 10'd1}));

        // Irregular run pattern; period 7 against the 8-pixel small line
        // makes run drop at every horizontal phase, including on strobes.
        for (int k = 0; k < 300; k++) begin
            tick((k % 7) < 4);
        end

        // Asynchronous reset between clock edges.
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_def", act_d, RESET_VEC);
        check("midreset_sml", act_s, RESET_VEC);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Full frames on the small raster (48 cycles per frame).
        repeat (47) tick(1'b1);
        check("sml_last_xy", 33'({dx_s, dy_s}), 33'({10'd7, 10'd5}));
        check("sml_last_strobe", 33'({le_s, fe_s, fc_s}), 33'({1'b1, 1'b1, 8'd0}));
        tick(1'b1);
        check("sml_frame1", 33'({dx_s, dy_s, bl_s, fc_s}), 33'({10'd0, 10'd0, 1'b1, 8'd1}));
        repeat (254 * 48) tick(1'b1);
        check("sml_fc255", 33'(fc_s), 33'(255));
        repeat (48) tick(1'b1);
        check("sml_fc_wrap", 33'({dx_s, dy_s, fc_s}), 33'({10'd0, 10'd0, 8'd0}));

        run = 1'b0;
        @(negedge clk);
        check("queue_drained", 33'(exp_q.size()), 33'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
